// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types and constants for the CPU/RAM memory handshake.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  // RW line encoding, shared by the request port and the RAM
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_moc_sync.sv
// mem_moc_sync: multi-flop synchronizer for the RAM MOC strobe plus a
// one-cycle rising-edge detector on the synchronized level.
module mem_moc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic moc,
  output logic moc_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // shift MOC through the synchronizer, remember last synchronized level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], moc};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // edge is visible in the same cycle the synchronized level first goes high
  assign moc_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: initiator side of the CPU/RAM handshake.
// One request at a time: latch request onto RAM lines, strobe MOV, wait for
// the synchronized MOC rise, return read data, drop Enable.
// Optional build macro MEM_TIMEOUT_EN adds a STROBE timeout that completes
// the transaction with RespErr=1 and RespData=0.
module mem_access_controller
  import mem_if_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic              ReqRW,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              ReqReady,
  output logic              RespValid,
  output logic [DATA_W-1:0] RespData,
  output logic              RespErr,
  output logic              MemEnable,
  output logic              MemMOV,
  output logic              MemRW,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataWr,
  input  logic [DATA_W-1:0] MemDataRd,
  input  logic              MemMOC
);

  mem_state_e        state;
  logic [DATA_W-1:0] rdata_q;
  logic              moc_rise;
  logic              timeout_hit;
  logic              strobe_done;

  mem_moc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_moc_sync (
    .clk      (Clk),
    .rst      (Reset),
    .moc      (MemMOC),
    .moc_rise (moc_rise)
  );

  assign ReqReady    = (state == IDLE) && !Reset;
  // a MOC edge wins over a coincident timeout
  assign strobe_done = (state == STROBE) && (moc_rise || timeout_hit);

  // handshake FSM with registered RAM-side and response outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      MemEnable  <= 1'b0;
      MemMOV     <= 1'b0;
      MemRW      <= 1'b0;
      MemAddress <= '0;
      MemDataWr  <= '0;
      RespValid  <= 1'b0;
      RespData   <= '0;
      rdata_q    <= '0;
    end else begin
      RespValid <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            MemRW      <= ReqRW;
            MemAddress <= ReqAddr;
            MemDataWr  <= ReqData;
            MemEnable  <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          // address/data/RW have had a full cycle to settle
          MemMOV <= 1'b1;
          state  <= STROBE;
        end
        STROBE: begin
          if (strobe_done) begin
            rdata_q <= (moc_rise && MemRW == RW_READ) ? MemDataRd : '0;
            MemMOV  <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          MemEnable <= 1'b0;
          RespValid <= 1'b1;
          RespData  <= rdata_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          err_q;

  assign timeout_hit = (state == STROBE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // count STROBE cycles; idle at zero everywhere else so entry starts clean
  always_ff @(posedge Clk) begin
    if (Reset)                tcnt <= '0;
    else if (state != STROBE) tcnt <= '0;
    else if (!timeout_hit)    tcnt <= tcnt + TW'(1);
  end

  // remember how STROBE ended and publish it with the response
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q   <= 1'b0;
      RespErr <= 1'b0;
    end else begin
      if (strobe_done)        err_q   <= !moc_rise;
      if (state == RELEASE)   RespErr <= err_q;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign RespErr     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: directed + randomized bench with a behavioural
// RAM (MOC raised a programmable number of cycles after MOV) and a reference
// memory holding the contents the RAM should have.
module tb_mem_access_controller;
  import mem_if_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqRW = 1'b0;
  logic [AW-1:0] ReqAddr = '0;
  logic [DW-1:0] ReqData = '0;
  logic          ReqReady, RespValid, RespErr;
  logic [DW-1:0] RespData;
  logic          MemEnable, MemMOV, MemRW;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemDataWr, MemDataRd;
  logic          MemMOC;

  always #5 Clk = ~Clk;

  mem_access_controller #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqRW(ReqRW), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .ReqReady(ReqReady), .RespValid(RespValid), .RespData(RespData),
    .RespErr(RespErr), .MemEnable(MemEnable), .MemMOV(MemMOV), .MemRW(MemRW),
    .MemAddress(MemAddress), .MemDataWr(MemDataWr), .MemDataRd(MemDataRd), .MemMOC(MemMOC)
  );

  // behavioural RAM
  logic [DW-1:0] ram     [0:255];
  logic [DW-1:0] ref_mem [0:255];
  bit            ram_en    = 1'b1;
  int            ram_delay = 0;
  int            ram_cnt   = 0;
  logic          moc_ram   = 1'b0;
  logic          moc_man   = 1'b0;

  assign MemMOC    = moc_ram | moc_man;
  assign MemDataRd = ram[MemAddress];

  always @(negedge Clk) begin
    if (!(MemEnable && MemMOV)) begin
      moc_ram = 1'b0;
      ram_cnt = ram_delay;
    end else if (ram_en && !moc_ram) begin
      if (ram_cnt == 0) begin
        moc_ram = 1'b1;
        if (MemRW == RW_WRITE) ram[MemAddress] = MemDataWr;
      end else begin
        ram_cnt--;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [AW-1:0] cur_addr;
  logic          cur_rw;
  logic [DW-1:0] cur_data;
  bit            stable_ok;

  // drive a request in the current cycle; returns 1 time unit after accept edge
  task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("req_ready_before_accept", ReqReady, 1);
    ReqValid = 1'b1; ReqRW = rw; ReqAddr = a; ReqData = d;
    cur_addr = a; cur_rw = rw; cur_data = d; stable_ok = 1'b1;
    @(posedge Clk); #1;
    ReqValid = 1'b0; ReqAddr = AW'($urandom); ReqData = $urandom; ReqRW = ~rw;
  endtask

  // wait for RespValid; lat = edges after accept, -1 if the bound expired
  task automatic wait_resp(input int k0, input int limit, output int lat,
                           output logic [DW-1:0] rd, output logic er);
    int  k;
    bit  got;
    k = k0; got = 1'b0; rd = '0; er = 1'b0;
    while (!got && k < limit) begin
      if (MemEnable && (MemAddress !== cur_addr || MemRW !== cur_rw || MemDataWr !== cur_data))
        stable_ok = 1'b0;
      if (MemMOV && !MemEnable) stable_ok = 1'b0;
      @(posedge Clk); #1;
      k++;
      if (RespValid) got = 1'b1;
    end
    lat = got ? k : -1;
    if (got) begin rd = RespData; er = RespErr; end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge Clk); #1; end
  endtask

  initial begin
    int            lat;
    logic [DW-1:0] rd;
    logic          er;
    bit            quiet;

    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'h1000_0000 + i * 32'h0101_0101;
      ref_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
    end

    // reset
    cycles(2);
    chk("rst_ready_low", ReqReady, 0);
    chk("rst_enable", MemEnable, 0);
    chk("rst_mov", MemMOV, 0);
    chk("rst_respvalid", RespValid, 0);
    chk("rst_respdata", RespData, 0);
    chk("rst_resperr", RespErr, 0);
    chk("rst_addr", MemAddress, 0);
    Reset = 1'b0;
    cycles(1);
    chk("idle_ready", ReqReady, 1);

    // directed write 0xDEADBEEF -> 0x05
    ram_en = 1'b1; ram_delay = 0;
    issue(RW_WRITE, 8'h05, 32'hDEADBEEF);
    chk("wr_enable_edge0", MemEnable, 1);
    chk("wr_mov_edge0", MemMOV, 0);
    chk("wr_addr", MemAddress, 32'h05);
    chk("wr_rw", MemRW, RW_WRITE);
    chk("wr_data", MemDataWr, 32'hDEADBEEF);
    @(posedge Clk); #1;
    chk("wr_mov_edge1", MemMOV, 1);
    wait_resp(1, 100, lat, rd, er);
    ref_mem[5] = 32'hDEADBEEF;
    chk("wr_latency", lat, 5);
    chk("wr_respdata", rd, 0);
    chk("wr_resperr", er, 0);
    chk("wr_stable", stable_ok, 1);
    chk("wr_enable_released", MemEnable, 0);
    cycles(1);
    chk("wr_resp_one_pulse", RespValid, 0);

    // directed read of 0x05, then back-to-back read issued in the RespValid cycle
    issue(RW_READ, 8'h05, 32'h0);
    wait_resp(0, 100, lat, rd, er);
    chk("rd_latency", lat, 5);
    chk("rd_respdata", rd, ref_mem[5]);
    chk("rd_resperr", er, 0);
    issue(RW_READ, 8'h21, 32'h5555_AAAA);
    chk("b2b_enable_rerise", MemEnable, 1);
    chk("b2b_resp_dropped", RespValid, 0);
    chk("b2b_respdata_hold", RespData, ref_mem[5]);
    wait_resp(0, 100, lat, rd, er);
    chk("b2b_latency", lat, 5);
    chk("b2b_respdata", rd, ref_mem[8'h21]);
    chk("b2b_stable", stable_ok, 1);
    cycles(2);

    // reset while in STROBE, then a late MOC
    ram_en = 1'b0;
    issue(RW_READ, 8'h30, 32'hCAFE_F00D);
    cycles(2);
    Reset = 1'b1;
    cycles(1);
    chk("rs_enable", MemEnable, 0);
    chk("rs_mov", MemMOV, 0);
    chk("rs_rw", MemRW, 0);
    chk("rs_addr", MemAddress, 0);
    chk("rs_datawr", MemDataWr, 0);
    chk("rs_respdata", RespData, 0);
    chk("rs_resperr", RespErr, 0);
    chk("rs_respvalid", RespValid, 0);
    chk("rs_ready_low", ReqReady, 0);
    Reset = 1'b0;
    quiet = 1'b1;
    moc_man = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) moc_man = 1'b0;
      cycles(1);
      if (RespValid || MemEnable || MemMOV || !ReqReady) quiet = 1'b0;
    end
    chk("rs_late_moc_ignored", quiet, 1);

    // MOC pulse in IDLE after a completed transaction
    ram_en = 1'b1; ram_delay = 1;
    issue(RW_READ, 8'h07, 32'h0);
    wait_resp(0, 100, lat, rd, er);
    chk("pre_idle_latency", lat, 6);
    chk("pre_idle_data", rd, ref_mem[7]);
    cycles(2);
    quiet = 1'b1;
    moc_man = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) moc_man = 1'b0;
      cycles(1);
      if (RespValid || MemEnable || !ReqReady) quiet = 1'b0;
    end
    chk("idle_moc_ignored", quiet, 1);
    chk("idle_moc_resp_hold", RespData, ref_mem[7]);

    // no MOC response at all
    ram_en = 1'b0;
    issue(RW_READ, 8'h09, 32'h0);
`ifdef MEM_TIMEOUT_EN
    wait_resp(0, 60, lat, rd, er);
    chk("to_latency", lat, 1 + TO + 1);
    chk("to_resperr", er, 1);
    chk("to_respdata", rd, 0);
    cycles(1);
    chk("to_enable_released", MemEnable, 0);
`else
    wait_resp(0, 40, lat, rd, er);
    chk("no_to_no_resp", lat, 32'hFFFF_FFFF);
    chk("no_to_mov_held", MemMOV, 1);
    chk("no_to_enable_held", MemEnable, 1);
    chk("no_to_not_ready", ReqReady, 0);
`endif
    Reset = 1'b1;
    cycles(1);
    Reset = 1'b0;
    cycles(1);

    // randomized transactions against the reference memory
    ram_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic          rw;
      logic [AW-1:0] a;
      logic [DW-1:0] d, exp;
      int            dly;
      rw  = logic'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 15));
      d   = $urandom;
      dly = $urandom_range(0, 3);
      ram_delay = dly;
      if (rw == RW_WRITE) begin
        ref_mem[a] = d;
        exp = '0;
      end else begin
        exp = ref_mem[a];
      end
      issue(rw, a, d);
      wait_resp(0, 100, lat, rd, er);
      chk("rnd_latency", lat, 5 + dly);
      chk("rnd_respdata", rd, exp);
      chk("rnd_resperr", er, 0);
      chk("rnd_stable", stable_ok, 1);
      cycles(1);
      chk("rnd_resp_one_pulse", RespValid, 0);
      cycles($urandom_range(0, 2));
      chk("rnd_respdata_hold", RespData, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
